// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared op encodings, rounding-mode constants and issue-entry type
package fpu_pkg;

  typedef enum logic [1:0] {
    OP_FMADD  = 2'b00,
    OP_FMSUB  = 2'b01,
    OP_FNMSUB = 2'b10,
    OP_FNMADD = 2'b11
  } fpu_op_e;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [2:0]  rm;
  } issue_entry_t;

endpackage

// File: rtl/fpu_rm_resolve.sv
// rtl/fpu_rm_resolve.sv - combinational static/dynamic rounding-mode resolution
module fpu_rm_resolve
  import fpu_pkg::*;
(
  input  logic [2:0] in_rm,
  input  logic [2:0] frm,
  output logic [2:0] rm_eff,
  output logic       illegal
);

  always_comb begin
    rm_eff  = RM_RNE;
    illegal = 1'b1;
    if (in_rm <= RM_RMM) begin
      rm_eff  = in_rm;
      illegal = 1'b0;
    end else if ((in_rm == RM_DYN) && (frm <= RM_RMM)) begin
      rm_eff  = frm;
      illegal = 1'b0;
    end
  end

endmodule

// File: rtl/fpu_fused_issue.sv
// rtl/fpu_fused_issue.sv - fused multiply-add issue stage: sign folding, rm resolve, 2-entry FIFO
module fpu_fused_issue
  import fpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [31:0]     in_a,
  input  logic [31:0]     in_b,
  input  logic [31:0]     in_c,
  input  logic [2:0]      in_rm,
  input  logic [2:0]      frm,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_a,
  output logic [31:0]     out_b,
  output logic [31:0]     out_c,
  output logic [2:0]      out_rm,
  output logic            illegal,
  output logic [CNTW-1:0] issue_cnt
);

  logic            ready_q;
  logic [1:0]      occ_q, occ_d;
  logic            wptr_q, wptr_d;
  logic            rptr_q, rptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            illegal_q;
  issue_entry_t    mem_q [DEPTH];

  logic            rm_illegal;
  logic [2:0]      rm_eff;
  logic            neg_prod, neg_add;
  logic            accept, push, pop;
  issue_entry_t    new_entry, head;
  fpu_op_e         op;

  fpu_rm_resolve u_rm (
    .in_rm   (in_rm),
    .frm     (frm),
    .rm_eff  (rm_eff),
    .illegal (rm_illegal)
  );

  // Downstream always does a*b+c, so negating a flips the product and negating c flips the addend.
  assign op       = fpu_op_e'(in_op);
  assign neg_prod = (op == OP_FNMSUB) || (op == OP_FNMADD);
  assign neg_add  = (op == OP_FMSUB)  || (op == OP_FNMADD);

  assign new_entry.a  = {in_a[31] ^ neg_prod, in_a[30:0]};
  assign new_entry.b  = in_b;
  assign new_entry.c  = {in_c[31] ^ neg_add, in_c[30:0]};
  assign new_entry.rm = rm_eff;

  assign in_ready  = ready_q && (occ_q < 2'(DEPTH));
  assign out_valid = (occ_q != 2'd0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && !rm_illegal && !flush;
  assign pop       = out_valid && out_ready && !flush;

  assign head      = mem_q[rptr_q];
  assign out_a     = head.a;
  assign out_b     = head.b;
  assign out_c     = head.c;
  assign out_rm    = head.rm;
  assign illegal   = illegal_q;
  assign issue_cnt = cnt_q;

  always_comb begin
    occ_d  = occ_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      occ_d  = 2'd0;
      wptr_d = 1'b0;
      rptr_d = 1'b0;
    end else begin
      if (push) wptr_d = ~wptr_q;
      if (pop) begin
        rptr_d = ~rptr_q;
        cnt_d  = cnt_q + CNTW'(1);
      end
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q   <= 1'b0;
      occ_q     <= 2'd0;
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ready_q   <= 1'b1;
      occ_q     <= occ_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      illegal_q <= accept && rm_illegal;
      if (push) mem_q[wptr_q] <= new_entry;
    end
  end

endmodule

// File: tb/tb_fpu_fused_issue.sv
// tb/tb_fpu_fused_issue.sv - directed plus randomized checks against a queue-based reference model
module tb_fpu_fused_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_a = '0, in_b = '0, in_c = '0;
  logic [2:0]  in_rm = 3'b000, frm = 3'b000;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, illegal;
  logic [31:0] out_a, out_b, out_c;
  logic [2:0]  out_rm;
  logic [15:0] issue_cnt;

  logic        w_in_ready, w_out_valid, w_illegal;
  logic [31:0] w_out_a, w_out_b, w_out_c;
  logic [2:0]  w_out_rm;
  logic [3:0]  w_issue_cnt;

  always #5 clk = ~clk;

  fpu_fused_issue #(.DEPTH(2), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_rm(in_rm), .frm(frm), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_c(out_c), .out_rm(out_rm), .illegal(illegal), .issue_cnt(issue_cnt)
  );

  // Narrow counter copy so counter wrap is reached in a short run.
  fpu_fused_issue #(.DEPTH(2), .CNTW(4)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_rm(in_rm), .frm(frm), .flush(flush),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_a(w_out_a), .out_b(w_out_b),
    .out_c(w_out_c), .out_rm(w_out_rm), .illegal(w_illegal), .issue_cnt(w_issue_cnt)
  );

  typedef struct {
    logic [31:0] a, b, c;
    logic [2:0]  rm;
  } ent_t;

  ent_t        mq[$];
  int unsigned exp_cnt = 0;
  bit          exp_ill = 0;
  bit          started = 0;
  int          ncmp = 0;
  int          nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit rm_ok(input logic [2:0] rm, input logic [2:0] f, output logic [2:0] eff);
    eff = 3'b000;
    if (rm <= 3'd4) begin eff = rm; return 1'b1; end
    if (rm == 3'd7 && f <= 3'd4) begin eff = f; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic drive(input bit v, input logic [1:0] op, input logic [31:0] a, b, c,
                       input logic [2:0] rm, f, input bit fl, rdy);
    in_valid = v; in_op = op; in_a = a; in_b = b; in_c = c;
    in_rm = rm; frm = f; flush = fl; out_ready = rdy;
  endtask

  // One clock: compare outputs to model state, then advance the model across the edge.
  task automatic cyc();
    bit exp_rdy, acc, ok, push, pop;
    logic [2:0] eff;
    ent_t e;
    exp_rdy = started && (mq.size() < 2);
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
    chk("illegal", {31'b0, illegal}, {31'b0, exp_ill});
    chk("issue_cnt", {16'b0, issue_cnt}, exp_cnt & 32'hFFFF);
    chk("issue_cnt_w", {28'b0, w_issue_cnt}, exp_cnt & 32'hF);
    if (mq.size() > 0) begin
      chk("out_a", out_a, mq[0].a);
      chk("out_b", out_b, mq[0].b);
      chk("out_c", out_c, mq[0].c);
      chk("out_rm", {29'b0, out_rm}, {29'b0, mq[0].rm});
    end
    acc  = in_valid && exp_rdy;
    ok   = rm_ok(in_rm, frm, eff);
    push = acc && ok && !flush;
    pop  = (mq.size() > 0) && out_ready && !flush;
    e.a  = in_a ^ (((in_op == 2'b10) || (in_op == 2'b11)) ? 32'h8000_0000 : 32'h0);
    e.b  = in_b;
    e.c  = in_c ^ (((in_op == 2'b01) || (in_op == 2'b11)) ? 32'h8000_0000 : 32'h0);
    e.rm = eff;
    @(posedge clk);
    exp_ill = acc && !ok;
    if (flush) mq.delete();
    else begin
      if (pop) begin void'(mq.pop_front()); exp_cnt++; end
      if (push) mq.push_back(e);
    end
    started = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    drive(0, 2'b00, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 0, rdy);
    cyc();
  endtask

  task automatic rand_req(input bit rdy);
    drive(1, 2'($urandom), $urandom, $urandom, $urandom, 3'($urandom_range(0, 4)),
          3'($urandom), 0, rdy);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'h0);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'h0);
    chk({tag, "_illegal"}, {31'b0, illegal}, 32'h0);
    chk({tag, "_cnt"}, {16'b0, issue_cnt}, 32'h0);
    chk({tag, "_cnt_w"}, {28'b0, w_issue_cnt}, 32'h0);
    chk({tag, "_out_a"}, out_a, 32'h0);
    chk({tag, "_out_b"}, out_b, 32'h0);
    chk({tag, "_out_c"}, out_c, 32'h0);
    chk({tag, "_out_rm"}, {29'b0, out_rm}, 32'h0);
  endtask

  int unsigned cnt0;

  initial begin
    #7;
    chk_reset_vals("rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    started = 1'b0;
    idle(0);
    idle(0);

    // FNMSUB with the literal operands
    drive(1, 2'b10, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 3'b000, 0, 1);
    cyc();
    drive(0, 2'b00, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 0, 1);
    chk("fnmsub_a", out_a, 32'hBF80_0000);
    chk("fnmsub_b", out_b, 32'h4000_0000);
    chk("fnmsub_c", out_c, 32'h4040_0000);
    chk("fnmsub_rm", {29'b0, out_rm}, 32'h0);
    cyc();
    chk("fnmsub_cnt", {16'b0, issue_cnt}, 32'h1);

    // FNMADD dynamic rm legal, then dynamic rm illegal
    drive(1, 2'b11, 32'h7FC0_0000, 32'h1234_5678, 32'h0000_0000, 3'b111, 3'b011, 0, 1);
    cyc();
    drive(0, 2'b00, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 0, 1);
    chk("fnmadd_a", out_a, 32'hFFC0_0000);
    chk("fnmadd_c", out_c, 32'h8000_0000);
    chk("fnmadd_rm", {29'b0, out_rm}, 32'h3);
    cyc();
    cnt0 = exp_cnt;
    drive(1, 2'b00, 32'h1, 32'h2, 32'h3, 3'b111, 3'b101, 0, 1);
    cyc();
    drive(0, 2'b00, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 0, 1);
    chk("dyn_ill_pulse", {31'b0, illegal}, 32'h1);
    chk("dyn_ill_noenq", {31'b0, out_valid}, 32'h0);
    cyc();
    chk("dyn_ill_cnt", {16'b0, issue_cnt}, cnt0 & 32'hFFFF);
    drive(1, 2'b00, 32'h1, 32'h2, 32'h3, 3'b101, 3'b000, 0, 1);
    cyc();
    idle(1);

    // Backpressure: three back-to-back requests, then drain in order
    for (int i = 0; i < 3; i++) begin
      rand_req(0);
      if (i == 2) chk("full_in_ready", {31'b0, in_ready}, 32'h0);
      cyc();
    end
    for (int i = 0; i < 3; i++) idle(1);

    // Occupancy 1 with push and pop together for 10 cycles
    rand_req(0);
    cyc();
    cnt0 = exp_cnt;
    for (int i = 0; i < 10; i++) begin
      rand_req(1);
      cyc();
      chk("steady_occ1", {31'b0, out_valid}, 32'h1);
    end
    chk("steady_cnt", {16'b0, issue_cnt}, (cnt0 + 10) & 32'hFFFF);
    idle(1);

    // Flush at occupancy 2 with in_valid asserted
    rand_req(0); cyc();
    rand_req(0); cyc();
    cnt0 = exp_cnt;
    rand_req(1);
    flush = 1'b1;
    cyc();
    drive(0, 2'b00, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 0, 1);
    chk("flush_valid", {31'b0, out_valid}, 32'h0);
    chk("flush_ready", {31'b0, in_ready}, 32'h1);
    chk("flush_cnt", {16'b0, issue_cnt}, cnt0 & 32'hFFFF);
    cyc();

    // Randomized traffic, including illegal modes and flushes
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom), $urandom, $urandom, $urandom,
            3'($urandom), 3'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
      cyc();
    end

    // Asynchronous reset in the middle of a drain
    rand_req(0); cyc();
    rand_req(0); cyc();
    idle(1);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    mq.delete();
    exp_cnt = 0;
    exp_ill = 0;
    started = 0;
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    idle(1);
    for (int i = 0; i < 20; i++) begin
      rand_req(1);
      cyc();
    end
    idle(1);
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
